// File: rtl/conv_window_reader.sv
// K x K window fetch stage: on a level start request, reads one window of the feature map from a
// synchronous-read memory into a flat window register, pulses done, then advances in raster order.
module conv_window_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [K*K*DATA_W-1:0] window,
  output logic [ADDR_W-1:0]     win_row,
  output logic [ADDR_W-1:0]     win_col,
  output logic                  done,
  output logic                  last_window
);

  localparam int unsigned NumEl = K * K;
  localparam int unsigned IdxW  = $clog2(NumEl + 1);

  localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(IMG_H - K);
  localparam logic [ADDR_W-1:0] LastCol = ADDR_W'(IMG_W - K);
  localparam logic [ADDR_W-1:0] KLast   = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] ImgWA   = ADDR_W'(IMG_W);
  localparam logic [IdxW-1:0]   IdxLast = IdxW'(NumEl - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StDone, StWaitLow} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       i_q, i_d, j_q, j_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    cap_en_q, cap_en_d;
  logic [IdxW-1:0]         cap_idx_q, cap_idx_d;
  logic [ADDR_W-1:0]       row_q, row_d, col_q, col_d;
  logic [K*K*DATA_W-1:0]   win_q, win_d;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    cap_en_d  = (state_q == StIssue);
    cap_idx_d = idx_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          i_d     = '0;
          j_d     = '0;
          idx_d   = '0;
        end
      end
      StIssue: begin
        idx_d = idx_q + 1'b1;
        // Row/column counters walk the window without a divider
        if (j_q == KLast) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        if (idx_q == IdxLast) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone: begin
        state_d = StWaitLow;
        if (row_q == LastRow && col_q == LastCol) begin
          row_d = '0;
          col_d = '0;
        end else if (col_q == LastCol) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StWaitLow: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Read data lands one cycle after issue; write it into the element issued last cycle
  always_comb begin
    win_d = win_q;
    for (int e = 0; e < int'(NumEl); e++) begin
      if (cap_en_q && cap_idx_q == IdxW'(e)) win_d[e*DATA_W +: DATA_W] = mem_rdata;
    end
  end

  always_comb begin
    mem_rd   = (state_q == StIssue);
    mem_addr = '0;
    if (mem_rd) mem_addr = (row_q + i_q) * ImgWA + col_q + j_q;
  end

  assign window      = win_q;
  assign win_row     = row_q;
  assign win_col     = col_q;
  assign done        = (state_q == StDone);
  assign last_window = done && (row_q == LastRow) && (col_q == LastCol);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      i_q       <= '0;
      j_q       <= '0;
      idx_q     <= '0;
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      idx_q     <= idx_d;
      cap_en_q  <= cap_en_d;
      cap_idx_q <= cap_idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      win_q     <= win_d;
    end
  end

endmodule
